muxn_arb: RTL and testbench
===========================

MUXN_ARB -- requirements
Module: muxn_arb

Interface
REQ-001 Parameter N, default 32, bit width of each data channel and of Y.
REQ-002 Parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SW, default $clog2(CHANNELS), width of S and Y_CHAN, derived and not overridden.
REQ-004 CLOCK  input  1  single clock; all state on rising edge.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 ENABLE  input  1  1 = new transfers may be accepted; 0 = acceptance frozen.
REQ-007 MODE  input  1  0 = fixed select by S; 1 = round-robin among valid channels.
REQ-008 S  input  SW  channel select, used only when MODE=0.
REQ-009 D  input  CHANNELS*N  flattened channel data; channel k occupies bits [k*N +: N].
REQ-010 D_VALID  input  CHANNELS  per-channel data valid.
REQ-011 D_READY  output  CHANNELS  per-channel accept strobe; at most one bit high.
REQ-012 Y  output  N  registered selected data.
REQ-013 Y_VALID  output  1  Y holds an unconsumed word.
REQ-014 Y_READY  input  1  downstream accepts Y this cycle.
REQ-015 Y_CHAN  output  SW  index of the channel that produced Y.

Function
REQ-016 The block SHALL hold one output register stage, giving a latency of exactly 1 cycle from input acceptance to Y_VALID=1.
REQ-017 The block SHALL be able to accept when ENABLE=1 and (Y_VALID=0 or Y_READY=1), giving full throughput of one word per cycle.
REQ-018 In MODE=0, the grant SHALL be channel S if D_VALID[S]=1; otherwise there SHALL be no grant; an S value >= CHANNELS SHALL produce no grant.
REQ-019 In MODE=1, the grant SHALL be the first channel with D_VALID=1, searching upward from ptr+1 modulo CHANNELS, where ptr is the last channel granted.
REQ-020 D_READY[g] SHALL be 1 only for the granted channel g, and only when the block can accept; D_READY SHALL be combinational from current inputs and state.
REQ-021 On accept, Y SHALL load D[g], Y_CHAN SHALL load g, and Y_VALID SHALL be set to 1.
REQ-022 When Y_VALID=1, Y_READY=1 and there is no accept, Y_VALID SHALL clear; Y and Y_CHAN SHALL hold their values.
REQ-023 When Y_VALID=1 and Y_READY=0, Y, Y_CHAN and Y_VALID SHALL remain stable.
REQ-024 ptr SHALL update to g only on an accept in MODE=1; an accept in MODE=0 SHALL leave ptr unchanged.
REQ-025 A MODE change SHALL take effect on the same cycle's grant; ptr SHALL be retained across MODE changes.
REQ-026 ENABLE=0 SHALL force D_READY to all zeros; draining of a held word via Y_READY SHALL still be allowed.
REQ-027 D_VALID deasserting without a D_READY SHALL be tolerated and SHALL cause no transfer.

Reset
REQ-028 While RESET_N=0, Y SHALL be 0, Y_VALID 0, Y_CHAN 0, and ptr CHANNELS-1, so that the first round-robin search starts at channel 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-030 Deassertion of RESET_N SHALL be synchronous to CLOCK by the integrating design; the block SHALL add no synchroniser.

Structure
REQ-031 Package mux_pkg SHALL hold the mode enum (MUX_FIXED=0, MUX_RR=1) and the MAX_CHANNELS=16 constant.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_arbiter (request vector and ptr in, grant index and grant-valid out).
REQ-033 The ptr register, the output register and the handshake SHALL live in muxn_arb.

Verification (N=32, CHANNELS=4)
REQ-034 Fixed mode: MODE=0, S=2, D[2]=32'h80000000, D_VALID=4'b0100, Y_READY=1 -> next cycle Y=32'h80000000, Y_CHAN=2, Y_VALID=1, and D_READY=4'b0100 on the accept cycle.
REQ-035 Round-robin fairness: MODE=1, D_VALID=4'b1111 held, Y_READY=1 for 8 cycles -> Y_CHAN sequence 0,1,2,3,0,1,2,3 with no bubbles.
REQ-036 Backpressure: Y_VALID=1, Y=32'h00000001, Y_READY=0 for 5 cycles with all channels valid -> Y stable, D_READY=0 throughout; when Y_READY rises, the next word appears on the following cycle.
REQ-037 Skip and wrap: MODE=1, ptr=1, D_VALID=4'b0001 -> grant channel 0; then D_VALID=4'b1001 -> grant channel 3.
REQ-038 Enable and reset: ENABLE=0 with D_VALID=4'b1111 -> D_READY=0 and a held word drains on Y_READY=1; RESET_N pulsed low mid-stream -> Y_VALID=0 and Y=0 before the next edge, and the next round-robin grant is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel mux/arbiter: mode encoding, channel limit,
// and the modular index helper used by the round-robin search.
package mux_pkg;

    typedef enum logic {
        MUX_FIXED = 1'b0,
        MUX_RR    = 1'b1
    } mux_mode_e;

    localparam int MAX_CHANNELS = 16;

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requesting channel above ptr, wrapping
// modulo CHANNELS, with ptr itself checked last.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SW-1:0]       ptr,
    output logic [SW-1:0]       gnt_idx,
    output logic                gnt_valid
);

    localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1'b1);

    // Priority scan starting at ptr+1; the first hit wins.
    always_comb begin
        int idx_v;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx_v     = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx_v = wrap_idx(int'(ptr), i, CHANNELS);
            if (!gnt_valid && (|(req & (ONE_HOT0 << idx_v)))) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(idx_v);
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/muxn_arb.sv
// CHANNELS-way data mux with fixed or round-robin selection feeding a single
// valid/ready output register stage.
module muxn_arb
    import mux_pkg::*;
#(
    parameter int N        = 32,
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic                  MODE,
    input  logic [SW-1:0]         S,
    input  logic [CHANNELS*N-1:0] D,
    input  logic [CHANNELS-1:0]   D_VALID,
    output logic [CHANNELS-1:0]   D_READY,
    output logic [N-1:0]          Y,
    output logic                  Y_VALID,
    input  logic                  Y_READY,
    output logic [SW-1:0]         Y_CHAN
);

    localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1'b1);

    mux_mode_e           mode_s;
    logic [SW-1:0]       ptr_r;
    logic [N-1:0]        y_r;
    logic                y_valid_r;
    logic [SW-1:0]       y_chan_r;
    logic [SW-1:0]       rr_idx_s;
    logic                rr_valid_s;
    logic                fixed_valid_s;
    logic [SW-1:0]       gnt_idx_s;
    logic                gnt_valid_s;
    logic                can_accept_s;
    logic                accept_s;
    logic [N-1:0]        sel_data_s;

    assign mode_s = mux_mode_e'(MODE);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SW       (SW)
    ) u_rr (
        .req       (D_VALID),
        .ptr       (ptr_r),
        .gnt_idx   (rr_idx_s),
        .gnt_valid (rr_valid_s)
    );

    // Out-of-range S shifts the one-hot mask off the end, so it can never grant.
    assign fixed_valid_s = (int'(S) < CHANNELS) && (|(D_VALID & (ONE_HOT0 << S)));

    // Grant selection by mode; a mode change applies to this cycle's grant.
    always_comb begin
        gnt_idx_s   = '0;
        gnt_valid_s = 1'b0;
        case (mode_s)
            MUX_FIXED: begin
                gnt_idx_s   = S;
                gnt_valid_s = fixed_valid_s;
            end
            MUX_RR: begin
                gnt_idx_s   = rr_idx_s;
                gnt_valid_s = rr_valid_s;
            end
            default: begin
                gnt_idx_s   = '0;
                gnt_valid_s = 1'b0;
            end
        endcase
    end

    assign can_accept_s = ENABLE && (!y_valid_r || Y_READY);
    assign accept_s     = can_accept_s && gnt_valid_s;

    // Per-channel accept strobe, one-hot on the granted channel.
    always_comb begin
        D_READY = '0;
        if (accept_s) begin
            D_READY = ONE_HOT0 << gnt_idx_s;
        end else begin
            D_READY = '0;
        end
    end

    // Data selection of the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt_idx_s == SW'(k)) begin
                sel_data_s = D[k*N +: N];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
            y_chan_r  <= '0;
            ptr_r     <= SW'(CHANNELS - 1);
        end else if (accept_s) begin
            y_r       <= sel_data_s;
            y_chan_r  <= gnt_idx_s;
            y_valid_r <= 1'b1;
            if (mode_s == MUX_RR) begin
                ptr_r <= gnt_idx_s;
            end
        end else if (y_valid_r && Y_READY) begin
            y_valid_r <= 1'b0;
        end
    end

    assign Y       = y_r;
    assign Y_VALID = y_valid_r;
    assign Y_CHAN  = y_chan_r;

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb (N=32, CHANNELS=4): directed cycles push expected
// words; a negedge monitor pops and compares every word the DUT hands downstream.
module tb_muxn_arb;

    typedef struct packed {
        logic [31:0] y;
        logic [1:0]  ch;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         mode;
    logic [1:0]   s;
    logic [127:0] d_bus;
    logic [3:0]   d_valid;
    logic [3:0]   d_ready;
    logic [31:0]  y;
    logic         y_valid;
    logic         y_ready;
    logic [1:0]   y_chan;

    logic [31:0]  chan_data [4];
    exp_t         exp_q [$];
    int           errors;
    int           checks;

    assign d_bus = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};

    muxn_arb #(.N(32), .CHANNELS(4)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .ENABLE  (enable),
        .MODE    (mode),
        .S       (s),
        .D       (d_bus),
        .D_VALID (d_valid),
        .D_READY (d_ready),
        .Y       (y),
        .Y_VALID (y_valid),
        .Y_READY (y_ready),
        .Y_CHAN  (y_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each word consumed downstream must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got chan %0d data %h expected none", y_chan, y);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("y_data", y, e.y);
                chk("y_chan", {30'd0, y_chan}, {30'd0, e.ch});
            end
        end
    end

    // One cycle of stimulus; g is the hand-computed granted channel, -1 for none.
    task automatic cyc(input logic en, input logic md, input logic [1:0] sel,
                       input logic [3:0] dv, input logic yr, input int g);
        logic [3:0] exp_rdy;
        enable  = en;
        mode    = md;
        s       = sel;
        d_valid = dv;
        y_ready = yr;
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        @(negedge clk);
        chk("d_ready", {28'd0, d_ready}, {28'd0, exp_rdy});
        if (g >= 0) begin
            exp_q.push_back({chan_data[g], 2'(g)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq [8];
        rr_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        errors = 0;
        checks = 0;
        chan_data[0] = 32'h00000001;
        chan_data[1] = 32'h11111111;
        chan_data[2] = 32'h80000000;
        chan_data[3] = 32'h33333333;
        rst_n   = 1'b0;
        enable  = 1'b0;
        mode    = 1'b0;
        s       = 2'd0;
        d_valid = 4'b0000;
        y_ready = 1'b0;
        #2;
        chk("reset_y", y, 32'h0);
        chk("reset_y_valid", {31'd0, y_valid}, 32'h0);
        chk("reset_y_chan", {30'd0, y_chan}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed select of channel 2, then drain it.
        cyc(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 2);
        cyc(1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, -1);
        // Fixed select of an idle channel grants nothing.
        cyc(1'b1, 1'b0, 2'd1, 4'b1101, 1'b1, -1);

        // Round-robin fairness with every channel requesting (ptr still 3).
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, rr_seq[i]);
        end

        // Backpressure: load channel 0 (data 1) and stall five cycles.
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, -1);
            chk("bp_y", y, 32'h00000001);
            chk("bp_y_valid", {31'd0, y_valid}, 32'h1);
        end
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 1);
        chk("bp_next_chan", {30'd0, y_chan}, 32'h1);
        cyc(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, -1);

        // Skip and wrap from ptr=1.
        cyc(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 0);
        cyc(1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, 3);
        cyc(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, -1);

        // Enable low: no accepts, held word still drains.
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 0);
        cyc(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, -1);
        cyc(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, -1);
        cyc(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, -1);
        chk("drained_y_valid", {31'd0, y_valid}, 32'h0);

        // Reset mid-stream with a word held.
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 1);
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, -1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", {31'd0, y_valid}, 32'h0);
        chk("async_rst_y", y, 32'h0);
        chk("async_rst_y_chan", {30'd0, y_chan}, 32'h0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 0);
        cyc(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, -1);
        cyc(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, -1);

        chk("final_y_valid", {31'd0, y_valid}, 32'h0);
        chk("scoreboard_empty", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
